// File: rtl/pacote_maquina.sv
// Shared definitions for the vending machine: FSM states, default prices and coin decoding.
package pacote_maquina;

    // Width of the credit register, in 25-cent units
    localparam int unsigned CW = 5;

    // Default machine parameters, in 25-cent units
    localparam int unsigned CAP_PADRAO        = 20;
    localparam int unsigned PRECO_CAFE_PADRAO = 4;
    localparam int unsigned PRECO_SOPA_PADRAO = 6;

    // Credit FSM states
    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        CREDITO    = 2'd1,
        DEVOLVENDO = 2'd2
    } estado_t;

    // Decoded coin: value in units plus invalid-code flag
    typedef struct packed {
        logic       invalida;
        logic [2:0] unidades;
    } moeda_dec_t;

    // Coin code to units: 00=1, 01=2, 10=4, 11=invalid
    function automatic moeda_dec_t decodifica_moeda(input logic [1:0] codigo);
        moeda_dec_t d;
        d.invalida = 1'b0;
        d.unidades = 3'd0;
        case (codigo)
            2'b00:   d.unidades = 3'd1;
            2'b01:   d.unidades = 3'd2;
            2'b10:   d.unidades = 3'd4;
            default: d.invalida = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decod_moeda.sv
// Combinational coin decoder: maps a coin code to its value and an invalid flag.
module decod_moeda
    import pacote_maquina::*;
(
    input  logic [1:0] valor,
    output moeda_dec_t dec_c
);

    // Pure lookup through the shared mapping
    always_comb begin
        dec_c = decodifica_moeda(valor);
    end

endmodule

// File: rtl/credito_moedas.sv
// Credit accumulator for the vending machine: accepts coins, debits sales and returns change.
module credito_moedas
    import pacote_maquina::*;
#(
    parameter int unsigned CAP        = CAP_PADRAO,
    parameter int unsigned PRECO_CAFE = PRECO_CAFE_PADRAO,
    parameter int unsigned PRECO_SOPA = PRECO_SOPA_PADRAO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          moeda_valid,
    input  logic [1:0]    moeda_valor,
    input  logic          cafeBtn,
    input  logic          sopaBtn,
    input  logic          venda_ok,
    input  logic          venda_sopa,
    input  logic          devolver,
    input  logic          troco_ack,
    output logic          dinheiro,
    output logic [CW-1:0] credito,
    output logic          moeda_rejeitada,
    output logic          troco_valid,
    output logic          ocupado
);

    // One extra bit so credit + coin never wraps before the CAP test
    localparam int unsigned SW = CW + 1;

    localparam logic [SW-1:0] CAP_S        = SW'(CAP);
    localparam logic [SW-1:0] PRECO_CAFE_S = SW'(PRECO_CAFE);
    localparam logic [SW-1:0] PRECO_SOPA_S = SW'(PRECO_SOPA);

    estado_t       estado;
    moeda_dec_t    dec_c;

    logic          ativo_c;
    logic          moeda_cand_c;
    logic          aceita_c;
    logic          debito_c;
    logic [SW-1:0] cred_s_c;
    logic [SW-1:0] moeda_s_c;
    logic [SW-1:0] preco_s_c;
    logic [SW-1:0] soma_c;
    logic [SW-1:0] liq_c;

    decod_moeda u_decod_moeda (
        .valor (moeda_valor),
        .dec_c (dec_c)
    );

    // Coins and sales act only outside DEVOLVENDO, and a return request in CREDITO pre-empts both
    assign ativo_c = (estado != DEVOLVENDO) && !(devolver && (estado == CREDITO));

    // Net credit: try the coin with the debit first, fall back to debit alone if the coin overflows CAP
    always_comb begin
        cred_s_c     = SW'(credito);
        preco_s_c    = venda_sopa ? PRECO_SOPA_S : PRECO_CAFE_S;
        moeda_cand_c = moeda_valid && !dec_c.invalida && ativo_c;
        moeda_s_c    = moeda_cand_c ? SW'(dec_c.unidades) : '0;
        soma_c       = cred_s_c + moeda_s_c;
        debito_c     = venda_ok && ativo_c && (preco_s_c <= soma_c);
        liq_c        = debito_c ? (soma_c - preco_s_c) : soma_c;
        aceita_c     = moeda_cand_c && (liq_c <= CAP_S);
        if (moeda_cand_c && !aceita_c) begin
            debito_c = venda_ok && ativo_c && (preco_s_c <= cred_s_c);
            liq_c    = debito_c ? (cred_s_c - preco_s_c) : cred_s_c;
        end
    end

    // Enough credit for the current button selection; never while returning change
    always_comb begin
        dinheiro = 1'b0;
        if ((estado != DEVOLVENDO) && cafeBtn) begin
            dinheiro = sopaBtn ? (SW'(credito) >= PRECO_SOPA_S)
                               : (SW'(credito) >= PRECO_CAFE_S);
        end
    end

    // State, credit and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado          <= OCIOSO;
            credito         <= '0;
            moeda_rejeitada <= 1'b0;
            troco_valid     <= 1'b0;
            ocupado         <= 1'b0;
        end else begin
            moeda_rejeitada <= moeda_valid && !aceita_c;
            case (estado)
                OCIOSO: begin
                    credito <= CW'(liq_c);
                    if (liq_c != '0) begin
                        estado <= CREDITO;
                    end
                end
                CREDITO: begin
                    if (devolver) begin
                        estado      <= DEVOLVENDO;
                        troco_valid <= 1'b1;
                        ocupado     <= 1'b1;
                    end else begin
                        credito <= CW'(liq_c);
                        if (liq_c == '0) begin
                            estado <= OCIOSO;
                        end
                    end
                end
                DEVOLVENDO: begin
                    if (troco_valid && troco_ack) begin
                        credito <= credito - CW'(1);
                        if (credito == CW'(1)) begin
                            estado      <= OCIOSO;
                            troco_valid <= 1'b0;
                            ocupado     <= 1'b0;
                        end
                    end
                end
                default: begin
                    estado      <= OCIOSO;
                    troco_valid <= 1'b0;
                    ocupado     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_credito_moedas.sv
// Self-checking bench for credito_moedas: directed scenarios plus random traffic against a behavioural model.
module tb_credito_moedas;

    localparam int CAP = 20;
    localparam int PC  = 4;
    localparam int PS  = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       moeda_valid;
    logic [1:0] moeda_valor;
    logic       cafeBtn;
    logic       sopaBtn;
    logic       venda_ok;
    logic       venda_sopa;
    logic       devolver;
    logic       troco_ack;
    logic       dinheiro;
    logic [4:0] credito;
    logic       moeda_rejeitada;
    logic       troco_valid;
    logic       ocupado;

    int n_chk = 0;
    int n_ok  = 0;

    // Model: credit amount, whether change is being returned, last-cycle rejection
    int m_cred;
    bit m_dev;
    bit m_rej;
    int n_cred;
    bit n_dev;
    bit n_rej;

    always #5 clk = ~clk;

    credito_moedas #(.CAP(CAP), .PRECO_CAFE(PC), .PRECO_SOPA(PS)) dut (
        .clk             (clk),
        .rst             (rst),
        .moeda_valid     (moeda_valid),
        .moeda_valor     (moeda_valor),
        .cafeBtn         (cafeBtn),
        .sopaBtn         (sopaBtn),
        .venda_ok        (venda_ok),
        .venda_sopa      (venda_sopa),
        .devolver        (devolver),
        .troco_ack       (troco_ack),
        .dinheiro        (dinheiro),
        .credito         (credito),
        .moeda_rejeitada (moeda_rejeitada),
        .troco_valid     (troco_valid),
        .ocupado         (ocupado)
    );

    task automatic chk(input string nome, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    endtask

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Next model state from the current inputs, straight from the machine's rules
    task automatic model_next();
        int price;
        int val;
        int tot;
        bit taken;
        price = venda_sopa ? PS : PC;
        val   = moeda_valid ? coin_units(moeda_valor) : 0;
        n_cred = m_cred;
        n_dev  = m_dev;
        n_rej  = 1'b0;
        taken  = 1'b0;
        if (m_dev) begin
            n_rej = moeda_valid;
            if (troco_ack) begin
                n_cred = m_cred - 1;
                if (n_cred == 0) n_dev = 1'b0;
            end
        end else if (devolver && m_cred > 0) begin
            n_dev = 1'b1;
            n_rej = moeda_valid;
        end else begin
            if (val > 0) begin
                tot = m_cred + val;
                if (venda_ok && price <= tot) tot -= price;
                if (tot <= CAP) begin
                    n_cred = tot;
                    taken  = 1'b1;
                end
            end
            if (!taken) begin
                n_rej = moeda_valid;
                tot = m_cred;
                if (venda_ok && price <= m_cred) tot -= price;
                n_cred = tot;
            end
        end
    endtask

    task automatic compare_all();
        int exp_din;
        exp_din = (!m_dev && cafeBtn) ? int'(m_cred >= (sopaBtn ? PS : PC)) : 0;
        chk("credito", int'(credito), m_cred);
        chk("moeda_rejeitada", int'(moeda_rejeitada), int'(m_rej));
        chk("troco_valid", int'(troco_valid), int'(m_dev));
        chk("ocupado", int'(ocupado), int'(m_dev));
        chk("dinheiro", int'(dinheiro), exp_din);
    endtask

    // One clock: predict, clock, compare 1 time unit after the edge
    task automatic cycle();
        model_next();
        @(posedge clk);
        #1;
        m_cred = n_cred;
        m_dev  = n_dev;
        m_rej  = n_rej;
        compare_all();
    endtask

    task automatic pulse(input bit mv, input logic [1:0] mc, input bit vo, input bit vs,
                         input bit dv, input bit ta);
        moeda_valid = mv;
        moeda_valor = mc;
        venda_ok    = vo;
        venda_sopa  = vs;
        devolver    = dv;
        troco_ack   = ta;
        cycle();
        moeda_valid = 1'b0;
        venda_ok    = 1'b0;
        devolver    = 1'b0;
        troco_ack   = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        pulse(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_cred = 0;
        m_dev  = 1'b0;
        m_rej  = 1'b0;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        moeda_valid = 1'b0;
        moeda_valor = 2'b00;
        cafeBtn = 1'b0;
        sopaBtn = 1'b0;
        venda_ok = 1'b0;
        venda_sopa = 1'b0;
        devolver = 1'b0;
        troco_ack = 1'b0;
        m_cred = 0;
        m_dev = 1'b0;
        m_rej = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_credito", int'(credito), 0);

        // Coins 10,10, then a coffee sale
        coin(2'b10);
        chk("lit_cred_4", int'(credito), 4);
        coin(2'b10);
        chk("lit_cred_8", int'(credito), 8);
        cafeBtn = 1'b1;
        sopaBtn = 1'b0;
        #1;
        chk("lit_dinheiro_cafe", int'(dinheiro), 1);
        pulse(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_venda_cafe", int'(credito), 4);
        cafeBtn = 1'b0;

        // Fill to 18, then CAP boundary
        coin(2'b10);
        coin(2'b10);
        coin(2'b10);
        coin(2'b01);
        chk("lit_cred_18", int'(credito), 18);
        coin(2'b10);
        chk("lit_cap_rej", int'(moeda_rejeitada), 1);
        chk("lit_cap_cred", int'(credito), 18);
        coin(2'b01);
        chk("lit_cred_20", int'(credito), 20);
        chk("lit_rej_clear", int'(moeda_rejeitada), 0);
        coin(2'b00);
        chk("lit_full_rej", int'(moeda_rejeitada), 1);
        coin(2'b11);
        chk("lit_invalid_rej", int'(moeda_rejeitada), 1);

        // Down to 4, then a soup that cannot be paid
        pulse(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_cred_4b", int'(credito), 4);
        cafeBtn = 1'b1;
        sopaBtn = 1'b1;
        #1;
        chk("lit_dinheiro_sopa", int'(dinheiro), 0);
        pulse(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_sopa_ignored", int'(credito), 4);
        cafeBtn = 1'b0;
        sopaBtn = 1'b0;

        // Empty, idle ack and idle devolver have no effect
        pulse(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lit_idle_ocupado", int'(ocupado), 0);

        // Credit 3, return change with stalls and a coin during return
        coin(2'b01);
        coin(2'b00);
        chk("lit_cred_3", int'(credito), 3);
        pulse(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_dev_ocupado", int'(ocupado), 1);
        chk("lit_dev_coin_rej", int'(moeda_rejeitada), 1);
        chk("lit_dev_cred", int'(credito), 3);
        pulse(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_troco_2", int'(credito), 2);
        pulse(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_troco_coin_rej", int'(moeda_rejeitada), 1);
        pulse(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_troco_1", int'(credito), 1);
        cycle();
        pulse(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_troco_0", int'(credito), 0);
        chk("lit_troco_valid_low", int'(troco_valid), 0);

        // Same-cycle coin and coffee sale at credit 2
        coin(2'b01);
        pulse(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_net_2", int'(credito), 2);
        chk("lit_net_rej", int'(moeda_rejeitada), 0);

        // Credit 5, enter return, reset between clock edges
        coin(2'b01);
        coin(2'b00);
        pulse(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_dev5_valid", int'(troco_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("lit_async_cred", int'(credito), 0);
        chk("lit_async_valid", int'(troco_valid), 0);
        chk("lit_async_ocupado", int'(ocupado), 0);
        do_reset();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cafeBtn = 1'($urandom_range(0, 1));
            sopaBtn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                pulse(1'($urandom_range(0, 99) < 35), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 99) < 50));
            end
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
